// File: rtl/hazard_detect_unit_pkg.sv
// Shared core encodings for hazard metadata and operand-forward selects.
// Used by decode, the hazard unit and the datapath operand muxes.
package hazard_detect_unit_pkg;

    localparam int REG_AW_DEFAULT = 5;

    // Shadow pipeline stage indices (EXE is the youngest entry).
    localparam int STG_EXE      = 0;
    localparam int STG_MEM      = 1;
    localparam int STG_WB       = 2;
    localparam int SHADOW_DEPTH = 3;

    typedef enum logic [1:0] {
        OPT_NONE  = 2'b00,
        OPT_ALU   = 2'b01,
        OPT_LOAD  = 2'b10,
        OPT_STORE = 2'b11
    } hazard_optype_e;

    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,
        FWD_EXE     = 2'b01,
        FWD_MEM_ALU = 2'b10,
        FWD_MEM_LD  = 2'b11
    } fwd_sel_e;

    // True for instruction types that write a destination register.
    function automatic logic is_writer(input logic [1:0] optype);
        logic result;
        case (optype)
            OPT_ALU:  result = 1'b1;
            OPT_LOAD: result = 1'b1;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/hazard_detect_unit_fwd_select.sv
// Per-operand forward selector: picks the youngest in-flight producer of
// the operand and reports whether that producer is a load still in EXE.
module fwd_select
    import hazard_detect_unit_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              rs_use,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [1:0]        exe_optype,
    input  logic [REG_AW-1:0] exe_rd,
    input  logic [1:0]        mem_optype,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [1:0]        fwd_sel,
    output logic              exe_load_hit
);

    logic     exe_hit_s;
    logic     mem_hit_s;
    fwd_sel_e sel_s;

    // Match the operand against EXE and MEM; x0 is never forwarded.
    always_comb begin
        exe_hit_s = 1'b0;
        mem_hit_s = 1'b0;
        if (rs_use && (rs_addr != {REG_AW{1'b0}})) begin
            exe_hit_s = is_writer(exe_optype) && (rs_addr == exe_rd);
            mem_hit_s = is_writer(mem_optype) && (rs_addr == mem_rd);
        end else begin
            exe_hit_s = 1'b0;
            mem_hit_s = 1'b0;
        end
    end

    // EXE wins over MEM; a load in EXE selects the regfile because the
    // stall will hold the consumer until the load reaches MEM.
    always_comb begin
        sel_s = FWD_RF;
        if (exe_hit_s) begin
            if (exe_optype == OPT_ALU) begin
                sel_s = FWD_EXE;
            end else begin
                sel_s = FWD_RF;
            end
        end else if (mem_hit_s) begin
            case (mem_optype)
                OPT_ALU:  sel_s = FWD_MEM_ALU;
                OPT_LOAD: sel_s = FWD_MEM_LD;
                default:  sel_s = FWD_RF;
            endcase
        end else begin
            sel_s = FWD_RF;
        end
    end

    assign fwd_sel      = sel_s;
    assign exe_load_hit = exe_hit_s && (exe_optype == OPT_LOAD);

endmodule

// File: rtl/hazard_detect_unit.sv
// Pipeline hazard responder: shadows EXE/MEM/WB destinations and drives
// stall, flush and forwarding selects for the 5-stage RV32I core.
module hazard_detect_unit
    import hazard_detect_unit_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic [REG_AW-1:0] rs1_addr_ID,
    input  logic [REG_AW-1:0] rs2_addr_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic [1:0]        hazard_optype_ID,
    input  logic              Branch_ID,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls
);

    typedef struct packed {
        logic [1:0]        optype;
        logic [REG_AW-1:0] rd;
    } shadow_t;

    shadow_t           shadow_r [SHADOW_DEPTH];
    logic [REG_AW-1:0] exe_rs2_r;
    logic              ls_r;

    logic [1:0] sel_a_s;
    logic [1:0] sel_b_s;
    logic       rs1_load_hit_s;
    logic       rs2_load_hit_s;
    logic       stall_s;
    logic       ls_next_s;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_use       (rs1use_ID),
        .rs_addr      (rs1_addr_ID),
        .exe_optype   (shadow_r[STG_EXE].optype),
        .exe_rd       (shadow_r[STG_EXE].rd),
        .mem_optype   (shadow_r[STG_MEM].optype),
        .mem_rd       (shadow_r[STG_MEM].rd),
        .fwd_sel      (sel_a_s),
        .exe_load_hit (rs1_load_hit_s)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_use       (rs2use_ID),
        .rs_addr      (rs2_addr_ID),
        .exe_optype   (shadow_r[STG_EXE].optype),
        .exe_rd       (shadow_r[STG_EXE].rd),
        .mem_optype   (shadow_r[STG_MEM].optype),
        .mem_rd       (shadow_r[STG_MEM].rd),
        .fwd_sel      (sel_b_s),
        .exe_load_hit (rs2_load_hit_s)
    );

    // Load-use stall; a store only needing the loaded value as write data
    // picks it up from WB later, so it does not stall.
    always_comb begin
        stall_s = 1'b0;
        if (rs1_load_hit_s) begin
            stall_s = 1'b1;
        end else if (rs2_load_hit_s && (hazard_optype_ID != OPT_STORE)) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Store in EXE whose data register is produced by the load in MEM.
    always_comb begin
        ls_next_s = 1'b0;
        if ((shadow_r[STG_EXE].optype == OPT_STORE) &&
            (shadow_r[STG_MEM].optype == OPT_LOAD) &&
            (exe_rs2_r == shadow_r[STG_MEM].rd) &&
            (shadow_r[STG_MEM].rd != {REG_AW{1'b0}})) begin
            ls_next_s = 1'b1;
        end else begin
            ls_next_s = 1'b0;
        end
    end

    // Shadow pipeline advance; a stall injects a bubble into EXE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                shadow_r[i] <= '{optype: OPT_NONE, rd: {REG_AW{1'b0}}};
            end
            exe_rs2_r <= {REG_AW{1'b0}};
        end else begin
            shadow_r[STG_WB]  <= shadow_r[STG_MEM];
            shadow_r[STG_MEM] <= shadow_r[STG_EXE];
            if (stall_s) begin
                shadow_r[STG_EXE] <= '{optype: OPT_NONE, rd: {REG_AW{1'b0}}};
                exe_rs2_r         <= {REG_AW{1'b0}};
            end else begin
                shadow_r[STG_EXE] <= '{optype: hazard_optype_ID, rd: rd_ID};
                exe_rs2_r         <= rs2_addr_ID;
            end
        end
    end

    // Store-data forward select, valid while the store sits in MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ls_r <= 1'b0;
        end else begin
            ls_r <= ls_next_s;
        end
    end

    // Reset forces the enables high and the flushes low even while
    // Branch_ID is still being driven by a stale decode.
    always_comb begin
        PC_EN_IF     = 1'b1;
        reg_FD_EN    = 1'b1;
        reg_FD_flush = 1'b0;
        reg_DE_flush = 1'b0;
        if (!rst) begin
            PC_EN_IF     = 1'b1;
            reg_FD_EN    = 1'b1;
            reg_FD_flush = 1'b0;
            reg_DE_flush = 1'b0;
        end else begin
            PC_EN_IF     = ~stall_s;
            reg_FD_EN    = ~stall_s;
            reg_DE_flush = stall_s;
            reg_FD_flush = Branch_ID & ~stall_s;
        end
    end

    assign forward_ctrl_A  = sel_a_s;
    assign forward_ctrl_B  = sel_b_s;
    assign forward_ctrl_ls = ls_r;

endmodule
